sync_div_counter: RTL and testbench
===================================

Name: sync_div_counter

Overview:
Parametrised successor to the team's divided-clock counter. A runtime-programmable prescaler produces a single-cycle enable tick, and a modulo-N up/down counter advances on that tick. No derived clocks: everything runs on clk. Used wherever a slow display/scan count is needed: seven-segment refresh, LED sequencing, timebases.

Parameters:
WIDTH, 4, counter width in bits.
MODULUS, 16, count range 0..MODULUS-1; legal range 2..2**WIDTH.
DIV_W, 8, width of the div_ratio input and prescaler.

Ports:
clk  in  1  single clock; all logic rising-edge.
rst  in  1  synchronous, active-high reset.
en  in  1  1 = prescaler runs; 0 = prescaler and counter hold.
div_ratio  in  DIV_W  ticks occur every div_ratio clk cycles; 0 treated as 1.
dir  in  1  0 = count up, 1 = count down; sampled on tick.
load  in  1  synchronous load strobe.
load_val  in  WIDTH  value loaded on load.
count  out  WIDTH  registered counter value.
tick_o  out  1  registered; high for one cycle in the cycle count shows a tick-advanced value.
wrap_o  out  1  registered; high for one cycle in the cycle count shows a wrapped value.

Behaviour:
- Reset (rst=1 at an edge): prescaler=0, count=0, tick_o=0, wrap_o=0. rst overrides all other inputs. Mid-operation reset discards any pending tick.
- Effective ratio R = (div_ratio==0) ? 1 : div_ratio.
- Prescaler, when en=1:
  - If prescaler >= R-1: internal tick=1 and prescaler is set to 0.
  - Otherwise prescaler increments.
  - The >= comparison makes a div_ratio decrease below the current prescaler value fire a tick on the next edge, never a 2**DIV_W-cycle stall.
- When en=0: prescaler, count and direction have no effect; tick_o and wrap_o are 0.
- Counter on tick, when load=0:
  - Up: MODULUS-1 goes to 0 with wrap; otherwise +1.
  - Down: 0 goes to MODULUS-1 with wrap; otherwise -1.
- Latency: after reset release with en=1, count=1 is first visible in cycle R (0-indexed from the first cycle with rst=0). Ticks then repeat every R cycles.
- R=1: count advances every cycle.
- Load:
  - Priority rst > load > tick.
  - count <= (load_val >= MODULUS) ? MODULUS-1 : load_val, i.e. load_val is clamped.
  - Prescaler is cleared to 0. tick_o=0 and wrap_o=0 in the following cycle.
  - A tick coincident with load is dropped.
  - Load acts regardless of en.
- dir changes take effect on the next tick only. No glitching of count between ticks.
- tick_o and wrap_o are registered alongside count, so they align with the updated value.

Optional Feature:
Macro SYNC_DIV_COUNTER_GRAY_EN.
- Defined: adds output port count_gray (out, WIDTH), a registered binary-to-Gray conversion of the next count value, updated in the same cycle as count; reset to 0. Intended for MODULUS=2**WIDTH clock-domain-crossing use; for other moduli it is a plain Gray encoding without the single-bit-change guarantee at wrap.
- Undefined: no port and no logic; remaining behaviour is identical.

Decomposition:
- Package sync_cnt_pkg:
  - constants DIR_UP=1'b0 and DIR_DOWN=1'b1;
  - function bin2gray(WIDTH-generic);
  - function for effective ratio (zero maps to 1).
- One sub-module: sync_prescaler (clk, rst, en, div_ratio, clear, tick), holding the prescaler counter and >= compare. The counter/load/wrap logic stays in sync_div_counter.

Test Plan:
- Reset and basic count: WIDTH=4, MODULUS=10, div_ratio=5, en=1, dir=0 after rst.
  - count=1 at cycle 5, 2 at cycle 10.
  - Wraps 9 to 0 at cycle 50 with wrap_o=1 for that single cycle.
  - tick_o is high at cycles 5, 10, 15, …
- Down and wrap: MODULUS=10, div_ratio=1, dir=1 from count=0.
  - count sequence 9, 8, …, 0, 9, with wrap_o high exactly with each 9.
- Load priority and clamp:
  - load=1, load_val=7 coincident with a tick gives count=7 and tick_o=0.
  - load_val=12 gives count=9.
  - Prescaler restarts, so the next advance comes div_ratio cycles later.
- Ratio change and zero ratio:
  - With prescaler at 6 and div_ratio=10, switching div_ratio to 3 gives a tick on the next edge, then every 3 cycles.
  - div_ratio=0 behaves exactly as 1.
- Enable hold and mid-operation reset:
  - en=0 for 20 cycles: count, prescaler, tick_o=0 and wrap_o=0 hold.
  - rst=1 for 1 cycle mid-count: all outputs 0 on the next cycle, and counting resumes from 0 with full R latency.
- Gray option, SYNC_DIV_COUNTER_GRAY_EN defined with MODULUS=16, div_ratio=1, up:
  - count_gray follows 0, 1, 3, 2, 6, …, 8, 0.
  - Exactly one bit changes per step, including at wrap.

Source files
------------

// File: rtl/sync_cnt_pkg.sv
// ============================================================================
//  Module   : sync_cnt_pkg
//  Purpose  : Shared constants and helper functions for sync_div_counter and
//             its prescaler.
//             - DIR_UP / DIR_DOWN : encoding of the dir input
//             - bin2gray()        : binary-to-Gray, width-generic up to 32 bits
//             - eff_ratio()       : divide ratio with 0 mapped to 1
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sync_cnt_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Callers zero-extend their operand to 32 bits and truncate the result back
  // to their own width. Zero extension keeps the top Gray bit correct because
  // the bit above the MSB is 0.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // A ratio of 0 has no sensible meaning, so it behaves as 1 (tick every cycle).
  function automatic logic [31:0] eff_ratio(input logic [31:0] ratio);
    return (ratio == 32'd0) ? 32'd1 : ratio;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_prescaler.sv
// ============================================================================
//  Module   : sync_prescaler
//  Purpose  : Runtime-programmable prescaler producing a single-cycle
//             combinational tick every R enabled cycles, R = max(div_ratio,1).
//  Ports    : clk       in   clock, rising edge
//             rst       in   synchronous active-high reset
//             en        in   1 = prescaler advances, 0 = holds
//             div_ratio in   [DIV_W] divide ratio (0 treated as 1)
//             clear     in   synchronous clear of the prescaler, beats en
//             tick      out  high in the cycle the prescaler wraps
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_prescaler
  import sync_cnt_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             clear,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_ratio_m1;
  logic             w_hit;

  assign w_ratio_m1 = DIV_W'(eff_ratio(32'(div_ratio)) - 32'd1);

  // ">=" rather than "==": if the ratio is lowered below the current count,
  // the prescaler fires on the next edge instead of running all the way round.
  assign w_hit = (r_cnt >= w_ratio_m1);
  assign tick  = en & ~clear & w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_hit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sync_div_counter.sv
// ============================================================================
//  Module   : sync_div_counter
//  Purpose  : Modulo-MODULUS up/down counter advanced by a prescaler tick,
//             single clock domain, with clamped synchronous load.
//  Ports    : clk        in   clock, rising edge
//             rst        in   synchronous active-high reset
//             en         in   1 = prescaler runs, 0 = prescaler/counter hold
//             div_ratio  in   [DIV_W] tick period in cycles (0 treated as 1)
//             dir        in   0 = up, 1 = down, sampled on tick
//             load       in   synchronous load strobe (beats tick, ignores en)
//             load_val   in   [WIDTH] load value, clamped to MODULUS-1
//             count      out  [WIDTH] registered count
//             tick_o     out  registered, high with each tick-advanced value
//             wrap_o     out  registered, high with each wrapped value
//             count_gray out  [WIDTH] registered Gray code of count
//                             (only with SYNC_DIV_COUNTER_GRAY_EN defined)
//  Options  : `define SYNC_DIV_COUNTER_GRAY_EN to add the count_gray output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_div_counter
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int DIV_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick_o,
  output logic             wrap_o
`ifdef SYNC_DIV_COUNTER_GRAY_EN
  ,
  output logic [WIDTH-1:0] count_gray
`endif
);

  localparam logic [WIDTH-1:0] c_MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [31:0]      c_MOD_32  = 32'(MODULUS);

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("sync_div_counter: MODULUS must lie in 2..2**WIDTH");
  end

  logic             w_tick;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tick_nxt;
  logic             w_wrap_nxt;

  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_wrap;

  sync_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_ratio (div_ratio),
    .clear     (load),
    .tick      (w_tick)
  );

  // Compare in 32 bits: MODULUS may equal 2**WIDTH, which does not fit WIDTH.
  assign w_load_clamped = (32'(load_val) >= c_MOD_32) ? c_MAX_VAL : load_val;

  always_comb begin
    w_count_nxt = r_count;
    w_tick_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (load) begin
      // A coincident tick is dropped; the prescaler is cleared via clear.
      w_count_nxt = w_load_clamped;
    end else if (w_tick) begin
      w_tick_nxt = 1'b1;
      if (dir == DIR_DOWN) begin
        if (r_count == '0) begin
          w_count_nxt = c_MAX_VAL;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end else begin
        if (r_count == c_MAX_VAL) begin
          w_count_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tick  <= w_tick_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign count  = r_count;
  assign tick_o = r_tick;
  assign wrap_o = r_wrap;

`ifdef SYNC_DIV_COUNTER_GRAY_EN
  logic [WIDTH-1:0] r_gray;

  // Encoding the next value keeps count_gray in the same cycle as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gray <= '0;
    end else begin
      r_gray <= WIDTH'(bin2gray(32'(w_count_nxt)));
    end
  end

  assign count_gray = r_gray;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_div_counter.sv
// ============================================================================
//  Module   : tb_sync_div_counter
//  Purpose  : Self-checking bench for sync_div_counter. A behavioural model
//             pushes expected outputs into a scoreboard queue each time
//             stimulus is applied; they are popped and compared after the
//             clock edge. A second instance (MODULUS=2**WIDTH, ratio 1, up)
//             runs free to cover full-range wrap and the Gray output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sync_div_counter;

  localparam int W     = 4;
  localparam int MOD   = 10;
  localparam int DW    = 8;
  localparam int MOD16 = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] div_ratio = 8'd1;
  logic          dir = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;

  logic [W-1:0]  count;
  logic          tick_o;
  logic          wrap_o;
  logic [W-1:0]  count16;
  logic          tick16;
  logic          wrap16;
`ifdef SYNC_DIV_COUNTER_GRAY_EN
  logic [W-1:0]  gray;
  logic [W-1:0]  gray16;
  logic [W-1:0]  prev_g16 = '0;
`endif

  always #5 clk = ~clk;

  sync_div_counter #(.WIDTH(W), .MODULUS(MOD), .DIV_W(DW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_ratio  (div_ratio),
    .dir        (dir),
    .load       (load),
    .load_val   (load_val),
    .count      (count),
    .tick_o     (tick_o),
    .wrap_o     (wrap_o)
`ifdef SYNC_DIV_COUNTER_GRAY_EN
    ,
    .count_gray (gray)
`endif
  );

  sync_div_counter #(.WIDTH(W), .MODULUS(MOD16), .DIV_W(DW)) u_dut16 (
    .clk        (clk),
    .rst        (rst),
    .en         (1'b1),
    .div_ratio  (8'd1),
    .dir        (1'b0),
    .load       (1'b0),
    .load_val   (4'd0),
    .count      (count16),
    .tick_o     (tick16),
    .wrap_o     (wrap16)
`ifdef SYNC_DIV_COUNTER_GRAY_EN
    ,
    .count_gray (gray16)
`endif
  );

  typedef struct {
    int cnt;
    bit tick;
    bit wrap;
    int c16;
    bit t16;
    bit w16;
    bit step16;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int m_presc = 0;
  int m_cnt   = 0;
  bit m_tick  = 0;
  bit m_wrap  = 0;
  int m16     = 0;
  bit m_t16   = 0;
  bit m_w16   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Predict the state after the coming edge from the inputs now applied.
  task automatic model_push();
    exp_t e;
    int   r;
    bit   step;
    step = 1'b0;
    if (rst) begin
      m_presc = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
      m16 = 0; m_t16 = 0; m_w16 = 0;
    end else begin
      if (load) begin
        m_cnt   = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
        m_presc = 0; m_tick = 0; m_wrap = 0;
      end else if (en) begin
        r = (div_ratio == 0) ? 1 : int'(div_ratio);
        if (m_presc >= r - 1) begin
          m_presc = 0;
          m_tick  = 1;
          if (dir == 1'b0) begin
            m_wrap = (m_cnt == MOD - 1);
            m_cnt  = (m_cnt + 1) % MOD;
          end else begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + MOD - 1) % MOD;
          end
        end else begin
          m_presc++;
          m_tick = 0; m_wrap = 0;
        end
      end else begin
        m_tick = 0; m_wrap = 0;
      end
      m_w16 = (m16 == MOD16 - 1);
      m16   = (m16 + 1) % MOD16;
      m_t16 = 1;
      step  = 1'b1;
    end
    e.cnt = m_cnt; e.tick = m_tick; e.wrap = m_wrap;
    e.c16 = m16; e.t16 = m_t16; e.w16 = m_w16; e.step16 = step;
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("count", int'(count), e.cnt);
    check_eq("tick_o", int'(tick_o), int'(e.tick));
    check_eq("wrap_o", int'(wrap_o), int'(e.wrap));
    check_eq("count16", int'(count16), e.c16);
    check_eq("tick16", int'(tick16), int'(e.t16));
    check_eq("wrap16", int'(wrap16), int'(e.w16));
`ifdef SYNC_DIV_COUNTER_GRAY_EN
    check_eq("gray", int'(gray), e.cnt ^ (e.cnt >> 1));
    check_eq("gray16", int'(gray16), e.c16 ^ (e.c16 >> 1));
    if (e.step16) check_eq("gray16_1bit", $countones(gray16 ^ prev_g16), 1);
    prev_g16 = gray16;
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    cyc();
    check_eq("rst_count", int'(count), 0);
    check_eq("rst_tick", int'(tick_o), 0);
    check_eq("rst_wrap", int'(wrap_o), 0);

    // Basic up count, R=5, MODULUS=10
    rst = 1'b0; en = 1'b1; div_ratio = 8'd5; dir = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      cyc();
      if (n == 4)  check_eq("lat_c4", int'(count), 0);
      if (n == 5)  begin check_eq("lat_c5", int'(count), 1); check_eq("lat_t5", int'(tick_o), 1); end
      if (n == 6)  check_eq("t6_low", int'(tick_o), 0);
      if (n == 10) check_eq("c10", int'(count), 2);
      if (n == 15) check_eq("t15", int'(tick_o), 1);
      if (n == 49) check_eq("c49", int'(count), 9);
      if (n == 50) begin check_eq("wrap_c50", int'(count), 0); check_eq("wrap_w50", int'(wrap_o), 1); end
    end

    // Down count, R=1
    dir = 1'b1; div_ratio = 8'd1;
    for (int n = 1; n <= 11; n++) begin
      cyc();
      if (n == 1)  begin check_eq("dn_c1", int'(count), 9); check_eq("dn_w1", int'(wrap_o), 1); end
      if (n == 2)  check_eq("dn_w2", int'(wrap_o), 0);
      if (n == 10) check_eq("dn_c10", int'(count), 0);
      if (n == 11) begin check_eq("dn_c11", int'(count), 9); check_eq("dn_w11", int'(wrap_o), 1); end
    end

    // Load coincident with tick, clamp, prescaler restart
    dir = 1'b0; div_ratio = 8'd5;
    run(4);
    load = 1'b1; load_val = 4'd7;
    cyc();
    check_eq("ld_c", int'(count), 7);
    check_eq("ld_t", int'(tick_o), 0);
    load = 1'b0;
    run(4);
    check_eq("ld_hold", int'(count), 7);
    cyc();
    check_eq("ld_next", int'(count), 8);
    load = 1'b1; load_val = 4'd12;
    cyc();
    check_eq("ld_clamp", int'(count), 9);
    load = 1'b0;

    // Ratio decrease below the prescaler value
    div_ratio = 8'd10;
    run(6);
    div_ratio = 8'd3;
    cyc();
    check_eq("rc_c", int'(count), 0);
    check_eq("rc_w", int'(wrap_o), 1);
    run(2);
    check_eq("rc_hold", int'(count), 0);
    cyc();
    check_eq("rc_next", int'(count), 1);

    // Ratio 0 behaves as 1
    div_ratio = 8'd0;
    run(3);
    check_eq("r0_c", int'(count), 4);
    check_eq("r0_t", int'(tick_o), 1);

    // Enable hold for 20 cycles
    div_ratio = 8'd5;
    run(2);
    en = 1'b0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (n == 19) begin
        check_eq("en_c", int'(count), 4);
        check_eq("en_t", int'(tick_o), 0);
      end
    end
    en = 1'b1;
    run(2);
    check_eq("en_resume_hold", int'(count), 4);
    cyc();
    check_eq("en_resume", int'(count), 5);

    // Load while disabled
    en = 1'b0; load = 1'b1; load_val = 4'd3;
    cyc();
    check_eq("ld_en0", int'(count), 3);
    load = 1'b0; en = 1'b1;
    run(5);
    check_eq("ld_en0_next", int'(count), 4);

    // Mid-operation reset
    run(2);
    rst = 1'b1;
    cyc();
    check_eq("mr_c", int'(count), 0);
    check_eq("mr_t", int'(tick_o), 0);
    check_eq("mr_w", int'(wrap_o), 0);
    rst = 1'b0;
    run(4);
    check_eq("mr_lat", int'(count), 0);
    cyc();
    check_eq("mr_c5", int'(count), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
